// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder
//
// Upstream feeder for an N x N output-stationary systolic MAC array.
// Holds operand matrices A (fed from the left edge, row-major) and B (fed
// from the top edge). On start it clears the array for one cycle, then streams
// A rows and B columns with a diagonal skew for 3N-2 cycles, then pulses done.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   load_valid      load element request
//   load_ready      feeder accepts loads (IDLE only, decoded from state)
//   load_sel        0 = write A, 1 = write B
//   load_row/col    element indices (out-of-range writes are dropped)
//   load_data       element value
//   start           begin a pass (IDLE only, never queued)
//   busy            from the cycle after start accept through the DONE cycle
//   done            one-cycle pulse, array results valid
//   arr_clr/arr_en  drive the array's rst / en
//   left_data       row i at [i*DATA_WIDTH +: DATA_WIDTH]
//   top_data        column j at [j*DATA_WIDTH +: DATA_WIDTH]
//   dbg_state_o     current FSM state (IDLE=0, CLEAR=1, STREAM=2, DONE=3)
//
// Handshake: a load element transfers on any rising edge where
// load_valid && load_ready; load_ready does not depend on load_valid.
module systolic_skew_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int N          = 3,
  parameter int IDX_W      = (N > 2) ? $clog2(N) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic                    load_sel,
  input  logic [IDX_W-1:0]        load_row,
  input  logic [IDX_W-1:0]        load_col,
  input  logic [DATA_WIDTH-1:0]   load_data,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    arr_clr,
  output logic                    arr_en,
  output logic [N*DATA_WIDTH-1:0] left_data,
  output logic [N*DATA_WIDTH-1:0] top_data,
  output logic [1:0]              dbg_state_o
);

  localparam int S_W = $clog2(3 * N - 2);
  localparam logic [S_W-1:0]   S_LAST = S_W'(3 * N - 3);
  localparam logic [IDX_W:0]   N_LIM  = (IDX_W + 1)'(N);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [S_W-1:0]          s_q, s_d;
  logic [DATA_WIDTH-1:0]   a_q [N][N];
  logic [DATA_WIDTH-1:0]   b_q [N][N];
  logic [N*DATA_WIDTH-1:0] left_d, top_d;
  logic                    busy_q, done_q, arr_clr_q, arr_en_q;
  logic [N*DATA_WIDTH-1:0] left_q, top_q;
  logic                    load_fire, load_in_range;

  assign load_ready    = (state_q == IDLE);
  assign load_fire     = load_valid && load_ready;
  assign load_in_range = ({1'b0, load_row} < N_LIM) && ({1'b0, load_col} < N_LIM);

  // Next-state logic and stream counter.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    case (state_q)
      IDLE:   if (start) state_d = CLEAR;
      CLEAR: begin
        state_d = STREAM;
        s_d     = '0;
      end
      STREAM: begin
        if (s_q == S_LAST) state_d = DONE;
        else               s_d     = s_q + S_W'(1);
      end
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Edge data for the upcoming stream cycle s_d. Row i carries A[i][s-i] and
  // column j carries B[s-j][j]; at most one k matches each (edge, s) pair.
  // Built from next-state so the registered data lines up with arr_en.
  always_comb begin
    left_d = '0;
    top_d  = '0;
    if (state_d == STREAM) begin
      for (int i = 0; i < N; i++) begin
        for (int k = 0; k < N; k++) begin
          if (s_d == S_W'(i + k)) begin
            left_d[i*DATA_WIDTH +: DATA_WIDTH] = a_q[i][k];
            top_d[i*DATA_WIDTH +: DATA_WIDTH]  = b_q[k][i];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      s_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      arr_clr_q <= 1'b0;
      arr_en_q  <= 1'b0;
      left_q    <= '0;
      top_q     <= '0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      busy_q    <= (state_d != IDLE);
      done_q    <= (state_d == DONE);
      arr_clr_q <= (state_d == CLEAR);
      arr_en_q  <= (state_d == STREAM);
      left_q    <= left_d;
      top_q     <= top_d;
    end
  end

  // Operand storage; only written in IDLE, so a pass sees a frozen copy.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          a_q[r][c] <= '0;
          b_q[r][c] <= '0;
        end
      end
    end else if (load_fire && load_in_range) begin
      if (load_sel) b_q[load_row][load_col] <= load_data;
      else          a_q[load_row][load_col] <= load_data;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign arr_clr     = arr_clr_q;
  assign arr_en      = arr_en_q;
  assign left_data   = left_q;
  assign top_data    = top_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Testbench for systolic_skew_feeder (N=3, DATA_WIDTH=8).
// Inputs are driven and outputs sampled on the falling clock edge.
// The expected array result is obtained by emulating the array's
// pass-through registers on the captured edge streams and comparing with
// C = A*B computed directly from the bench's own copy of the operands.
module tb_systolic_skew_feeder;
  localparam int DW = 8;
  localparam int N  = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_valid, load_ready, load_sel;
  logic [1:0]    load_row, load_col;
  logic [DW-1:0] load_data;
  logic          start, busy, done, arr_clr, arr_en;
  logic [N*DW-1:0] left_data, top_data;
  logic [1:0]    dbg_state_o;

  always #5 clk = ~clk;

  systolic_skew_feeder #(.DATA_WIDTH(DW), .N(N)) dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_ready(load_ready), .load_sel(load_sel),
    .load_row(load_row), .load_col(load_col), .load_data(load_data),
    .start(start), .busy(busy), .done(done),
    .arr_clr(arr_clr), .arr_en(arr_en),
    .left_data(left_data), .top_data(top_data),
    .dbg_state_o(dbg_state_o)
  );

  typedef struct packed {
    logic [8:0][7:0]  a;
    logic [8:0][7:0]  b;
    logic [8:0][31:0] c;
  } vec_t;

  vec_t vecs [6];
  int   errors = 0;
  int   checks = 0;
  int   ma [3][3];
  int   mb [3][3];
  int   exp_c [3][3];
  int   lcap [3][7];
  int   tcap [3][7];

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic load(input bit sel, input int row, input int col, input int val);
    @(negedge clk);
    start = 1'b0;
    chk("load_ready_idle", longint'(load_ready), 1);
    load_valid = 1'b1;
    load_sel   = sel;
    load_row   = 2'(row);
    load_col   = 2'(col);
    load_data  = 8'(val);
    if (row < N && col < N) begin
      if (sel) mb[row][col] = val;
      else     ma[row][col] = val;
    end
  endtask

  task automatic set_exp_from_model();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        exp_c[i][j] = 0;
        for (int k = 0; k < N; k++) exp_c[i][j] += ma[i][k] * mb[k][j];
      end
  endtask

  function automatic int edge_val(input bit is_top, input int idx, input int s);
    int k;
    k = s - idx;
    if (k < 0 || k >= N) return 0;
    return is_top ? mb[k][idx] : ma[idx][k];
  endfunction

  // One full pass from start accept (edge T) to T+11, checking every cycle.
  task automatic run_pass(input string tag, input bit pre_started,
                          input bit drv_load, input bit drv_start);
    logic [N*DW-1:0] el, et;
    int s, acc, u;
    if (!pre_started) begin
      @(negedge clk);
      load_valid = 1'b0;
      start      = 1'b1;
    end
    for (int cyc = 1; cyc <= 11; cyc++) begin
      @(negedge clk);
      chk($sformatf("%s clr c%0d", tag, cyc), longint'(arr_clr), longint'(cyc == 1));
      chk($sformatf("%s en c%0d", tag, cyc), longint'(arr_en), longint'(cyc >= 2 && cyc <= 8));
      chk($sformatf("%s done c%0d", tag, cyc), longint'(done), longint'(cyc == 9));
      chk($sformatf("%s busy c%0d", tag, cyc), longint'(busy), longint'(cyc <= 9));
      chk($sformatf("%s ready c%0d", tag, cyc), longint'(load_ready), longint'(cyc >= 10));
      el = '0;
      et = '0;
      if (cyc >= 2 && cyc <= 8) begin
        s = cyc - 2;
        for (int i = 0; i < N; i++) begin
          el[i*DW +: DW] = 8'(edge_val(1'b0, i, s));
          et[i*DW +: DW] = 8'(edge_val(1'b1, i, s));
          lcap[i][s] = int'($signed(left_data[i*DW +: DW]));
          tcap[i][s] = int'($signed(top_data[i*DW +: DW]));
        end
      end
      chk($sformatf("%s left c%0d", tag, cyc), longint'(left_data), longint'(el));
      chk($sformatf("%s top c%0d", tag, cyc), longint'(top_data), longint'(et));
      start      = drv_start && cyc >= 3 && cyc <= 6;
      load_valid = drv_load && cyc <= 8;
      if (drv_load) begin
        load_sel  = 1'b0;
        load_row  = 2'd0;
        load_col  = 2'd0;
        load_data = 8'h55;
      end
    end
    start      = 1'b0;
    load_valid = 1'b0;
    // Cell (i,j) pairs left sample t (delayed j) with top sample u (delayed i).
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        acc = 0;
        for (int t = 0; t < 3 * N - 2; t++) begin
          u = t + j - i;
          if (u >= 0 && u < 3 * N - 2) acc += lcap[i][t] * tcap[j][u];
        end
        chk($sformatf("%s C[%0d][%0d]", tag, i, j), longint'(acc), longint'(exp_c[i][j]));
      end
  endtask

  initial begin
    int c1 [9] = '{30, 36, 42, 66, 81, 96, 102, 126, 150};
    int bv, sum;
    bit done_seen;

    rst = 1'b1; load_valid = 1'b0; load_sel = 1'b0; load_row = '0;
    load_col = '0; load_data = '0; start = 1'b0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin ma[i][j] = 0; mb[i][j] = 0; end
    repeat (3) @(negedge clk);
    chk("rst load_ready", longint'(load_ready), 1);
    chk("rst busy", longint'(busy), 0);
    chk("rst done", longint'(done), 0);
    chk("rst arr_clr", longint'(arr_clr), 0);
    chk("rst arr_en", longint'(arr_en), 0);
    chk("rst left", longint'(left_data), 0);
    chk("rst top", longint'(top_data), 0);
    chk("rst state", longint'(dbg_state_o), 0);
    rst = 1'b0;

    // Vector table: counting matrix squared, identity times signed B,
    // all -128, and three random pairs.
    for (int k = 0; k < 9; k++) begin
      vecs[0].a[k] = 8'(k + 1);
      vecs[0].b[k] = 8'(k + 1);
      vecs[0].c[k] = 32'(c1[k]);
      bv = (k % 2 == 0) ? -(k + 1) : (k + 1);
      vecs[1].a[k] = (k % 4 == 0) ? 8'd1 : 8'd0;
      vecs[1].b[k] = 8'(bv);
      vecs[1].c[k] = 32'(bv);
      vecs[2].a[k] = 8'h80;
      vecs[2].b[k] = 8'h80;
      vecs[2].c[k] = 32'd49152;
    end
    for (int v = 3; v < 6; v++) begin
      for (int k = 0; k < 9; k++) begin
        vecs[v].a[k] = 8'($urandom_range(0, 255));
        vecs[v].b[k] = 8'($urandom_range(0, 255));
      end
      for (int r = 0; r < 3; r++)
        for (int cc = 0; cc < 3; cc++) begin
          sum = 0;
          for (int k = 0; k < 3; k++)
            sum += int'($signed(vecs[v].a[3*r+k])) * int'($signed(vecs[v].b[3*k+cc]));
          vecs[v].c[3*r+cc] = 32'(sum);
        end
    end

    for (int v = 0; v < 6; v++) begin
      for (int r = 0; r < 3; r++)
        for (int cc = 0; cc < 3; cc++) begin
          load(1'b0, r, cc, int'($signed(vecs[v].a[3*r+cc])));
          load(1'b1, r, cc, int'($signed(vecs[v].b[3*r+cc])));
          exp_c[r][cc] = int'(vecs[v].c[3*r+cc]);
        end
      run_pass($sformatf("vec%0d", v), 1'b0, 1'b0, 1'b0);
      if (v == 2) run_pass("rerun", 1'b0, 1'b0, 1'b0);
    end

    // Loads attempted during a pass must be refused and leave storage alone.
    set_exp_from_model();
    run_pass("load_in_stream", 1'b0, 1'b1, 1'b0);
    run_pass("after_load_in_stream", 1'b0, 1'b0, 1'b0);

    // start during STREAM is ignored; cycles 10 and 11 must stay idle.
    run_pass("start_in_stream", 1'b0, 1'b0, 1'b1);

    // Out-of-range indices complete the handshake but write nothing.
    load(1'b0, 3, 1, 77);
    load(1'b1, 1, 3, 77);
    load(1'b0, 3, 3, 77);
    run_pass("out_of_range", 1'b0, 1'b0, 1'b0);

    // start and a load in the same IDLE cycle: the load is used in the pass.
    load(1'b0, 1, 1, -50);
    start = 1'b1;
    set_exp_from_model();
    run_pass("start_with_load", 1'b1, 1'b0, 1'b0);

    // Reset in the middle of the stream (s=4).
    @(negedge clk);
    load_valid = 1'b0;
    start      = 1'b1;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("pre_rst arr_en", longint'(arr_en), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst load_ready", longint'(load_ready), 1);
    chk("mid_rst busy", longint'(busy), 0);
    chk("mid_rst done", longint'(done), 0);
    chk("mid_rst arr_clr", longint'(arr_clr), 0);
    chk("mid_rst arr_en", longint'(arr_en), 0);
    chk("mid_rst left", longint'(left_data), 0);
    chk("mid_rst top", longint'(top_data), 0);
    chk("mid_rst state", longint'(dbg_state_o), 0);
    rst = 1'b0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin ma[i][j] = 0; mb[i][j] = 0; end
    done_seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done) done_seen = 1'b1;
    end
    chk("no_done_after_rst", longint'(done_seen), 0);
    set_exp_from_model();
    run_pass("post_rst_zero", 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/systolic_skew_feeder.md
# systolic_skew_feeder

Upstream feeder for the N×N output-stationary systolic MAC array. It holds operand matrices A (row-major, fed from the left) and B (fed from the top), loaded element-by-element through a valid/ready port. On `start` it clears the array, then streams A rows and B columns into the array edges with the diagonal skew needed for C = A·B to accumulate in place. It drives the array's clear and enable, and pulses `done` once every cell's `acc_out` holds its final dot product.

## Interface
- `DATA_WIDTH`, 8: operand width, two's complement, passed through unmodified.
- `N`, 3: array dimension, N ≥ 2; `IDX_W` = $clog2(N), minimum 1.
- Reset is `rst`: synchronous, active-high. Clock is `clk`.
- `clk`  in  1  clock
- `rst`  in  1  synchronous active-high reset
- `load_valid`  in  1  load element request
- `load_ready`  out  1  feeder accepts loads; high only in IDLE
- `load_sel`  in  1  0 = write A, 1 = write B
- `load_row`  in  IDX_W  element row index
- `load_col`  in  IDX_W  element column index
- `load_data`  in  DATA_WIDTH  element value
- `start`  in  1  begin a multiply pass; accepted only in IDLE
- `busy`  out  1  high from the cycle after `start` is accepted through the DONE cycle
- `done`  out  1  one-cycle pulse; array results valid
- `arr_clr`  out  1  drives the array's `rst`
- `arr_en`  out  1  drives the array's `en`
- `left_data`  out  N*DATA_WIDTH  row i at bits [i*DATA_WIDTH +: DATA_WIDTH], to `in_left` of cell (i,0)
- `top_data`  out  N*DATA_WIDTH  column j at bits [j*DATA_WIDTH +: DATA_WIDTH], to `in_top` of cell (0,j)

## Operation
- Storage is two N×N register arrays, A and B. Both clear to 0 on `rst`.
- A load happens when `load_valid && load_ready`. It writes `load_data` to A[row][col] or B[row][col] according to `load_sel`.
  - If `load_row` ≥ N or `load_col` ≥ N, the handshake still completes but nothing is written.
- The FSM has four states: IDLE, CLEAR, STREAM and DONE.
  - IDLE: `load_ready`=1. If `start` is high, go to CLEAR.
  - CLEAR: lasts 1 cycle with `arr_clr`=1. Go to STREAM with stream counter s=0.
  - STREAM: lasts 3N−2 cycles with `arr_en`=1 and s incrementing each cycle. After s=3N−3, go to DONE.
  - DONE: lasts 1 cycle with `done`=1. Go to IDLE.
- During stream cycle s, the edge outputs are:
  - `left_data` row i = A[i][s−i] when 0 ≤ s−i < N, otherwise 0.
  - `top_data` column j = B[s−j][j] when 0 ≤ s−j < N, otherwise 0.
- Outside STREAM, `left_data` and `top_data` are 0. This means zeros flush through the array pass-through registers.
- This skew makes cell (i,j) see A[i][k] and B[k][j] in the same cycle for every k. Zero padding adds nothing to the accumulator.
- No arithmetic is done here. Accumulator width and sign extension are the array's responsibility.
- If `start` and a load handshake occur in the same IDLE cycle, both are honoured. The written element is used in the pass.
- `start` outside IDLE is ignored, not queued.
- While not in IDLE, `load_ready`=0 and storage is frozen. A and B persist across passes, so a pass can be re-run without reloading.

## Timing
- Reset values: `load_ready`=1, `busy`=0, `done`=0, `arr_clr`=0, `arr_en`=0, `left_data`=0, `top_data`=0, state IDLE, A=B=0.
- All outputs are registered, except `load_ready`, which is decoded from the state register.
- Let `start` be accepted at edge T:
  - Cycle T+1: `arr_clr`=1, `busy`=1.
  - Cycles T+2 … T+3N−1: `arr_en`=1, with stream data aligned to `arr_en` in the same cycle.
  - Cycle T+3N: `done`=1, `arr_en`=0.
  - Cycle T+3N+1: back in IDLE, `busy`=0.
- For N=3, `done` arrives 9 cycles after the accept edge. Each pass takes 10 cycles, and back-to-back `start` gives one pass per 10 cycles.
- `acc_out` of every cell is final from the `done` cycle onward. It holds until the next CLEAR.
- `rst` mid-pass forces every output and the storage to its reset value on the next edge. No `done` is generated. The array must also be reset by the same `rst`.

## Test plan
- Load A=[[1,2,3],[4,5,6],[7,8,9]] and B=A, then start → `done` exactly 9 cycles after accept. `acc_out` = [[30,36,42],[66,81,96],[102,126,150]].
- Load A = identity and B = the values 1..9 with signs alternating from −1 → C = B. Check the `left_data`/`top_data` skew cycle by cycle; for example, at s=2, row 2 = A[2][0] and column 2 = B[0][2].
- Load A and B with all entries −128 → every C entry = 49152. Rerun `start` without reloading → identical result, `arr_clr` pulse seen before the first `arr_en`.
- Assert `load_valid` during STREAM → `load_ready`=0 and storage unchanged. Write with `load_row`=3 in IDLE → handshake completes, no element changes.
- Assert `start` during STREAM → ignored, `done` still at T+9. Assert `start` and `load_valid` in the same IDLE cycle → the loaded value appears in the result.
- Assert `rst` at s=4 → next cycle all outputs 0, state IDLE, A=B=0. No `done` pulse follows.
